// File: rtl/score_display_mux_if.sv
// Score load and display pin bundle shared by the score source, the display driver and the pads.
interface score_display_mux_if #(
   parameter int SCORE_W = 14
);
   logic [SCORE_W-1:0] score;
   logic               score_valid;
   logic               blank_lz;
   logic               busy;
   logic               overflow;
   logic [7:0]         anode;
   logic [6:0]         segment;

   modport master (
      output score, score_valid, blank_lz,
      input  busy, overflow, anode, segment
   );

   modport slave (
      input  score, score_valid, blank_lz,
      output busy, overflow, anode, segment
   );
endinterface

// File: rtl/score_display_mux.sv
// Binary score to BCD (double-dabble) converter feeding a time-multiplexed seven-segment scan.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a score strobe, display holds last commit
// ST_SHIFT  | SCORE_W add-3/shift steps on the BCD work register
// ST_COMMIT | work register copied to display, chain to pending load
module score_display_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int SCORE_W     = 14,
   parameter int REFRESH_DIV = 100000
) (
   input logic                clk,
   input logic                rst_n,
   score_display_mux_if.slave sdm
);
   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int RC_W  = $clog2(REFRESH_DIV);

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < n; i++) p = p * 32'd10;
      return p;
   endfunction

   localparam logic [31:0] MAX_VAL = pow10(NUM_DIGITS) - 32'd1;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t             state_q;
   logic               busy_q;
   logic               overflow_q;
   logic               ovf_cur_q;
   logic [SCORE_W-1:0] bin_q;
   logic [BCD_W-1:0]   work_q;
   logic [4:0]         sh_cnt_q;
   logic               pend_q;
   logic [SCORE_W-1:0] pend_val_q;
   logic               pend_ovf_q;
   logic [BCD_W-1:0]   disp_q;

   logic [RC_W-1:0]    ref_cnt_q;
   logic               tick_q;
   logic [2:0]         idx_q;
   logic [7:0]         anode_q;
   logic [6:0]         segment_q;

   logic               load_ovf;
   logic [SCORE_W-1:0] load_val;
   logic [BCD_W-1:0]   work_adj;
   logic [3:0]         cur_nib;
   logic               cur_blank;
   logic               upper_zero;

   // Out-of-range scores saturate to all nines before conversion.
   assign load_ovf = (32'(sdm.score) > MAX_VAL);
   assign load_val = load_ovf ? SCORE_W'(MAX_VAL) : sdm.score;

   always_comb begin
      work_adj = work_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
   end

   // A digit is a leading zero when it and every digit above it are zero.
   always_comb begin
      cur_nib    = 4'd0;
      cur_blank  = 1'b0;
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (disp_q[4*i +: 4] == 4'd0);
         if (3'(i) == idx_q) begin
            cur_nib   = disp_q[4*i +: 4];
            cur_blank = upper_zero && (i != 0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
         ovf_cur_q  <= 1'b0;
         bin_q      <= '0;
         work_q     <= '0;
         sh_cnt_q   <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         pend_ovf_q <= 1'b0;
         disp_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sdm.score_valid) begin
                  bin_q     <= load_val;
                  ovf_cur_q <= load_ovf;
                  work_q    <= '0;
                  sh_cnt_q  <= 5'(SCORE_W - 1);
                  busy_q    <= 1'b1;
                  state_q   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               work_q <= {work_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
               bin_q  <= bin_q << 1;
               if (sh_cnt_q == 5'd0) state_q <= ST_COMMIT;
               else sh_cnt_q <= sh_cnt_q - 5'd1;
               if (sdm.score_valid) begin
                  pend_q     <= 1'b1;
                  pend_val_q <= load_val;
                  pend_ovf_q <= load_ovf;
               end
            end
            ST_COMMIT: begin
               disp_q     <= work_q;
               overflow_q <= ovf_cur_q;
               pend_q     <= 1'b0;
               // A strobe landing in this very cycle is newer than anything pending.
               if (sdm.score_valid || pend_q) begin
                  bin_q     <= sdm.score_valid ? load_val : pend_val_q;
                  ovf_cur_q <= sdm.score_valid ? load_ovf : pend_ovf_q;
                  work_q    <= '0;
                  sh_cnt_q  <= 5'(SCORE_W - 1);
                  state_q   <= ST_SHIFT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt_q <= '0;
         tick_q    <= 1'b0;
         idx_q     <= 3'd0;
         anode_q   <= 8'hFF;
         segment_q <= 7'h7F;
      end else begin
         if (ref_cnt_q == RC_W'(REFRESH_DIV - 1)) ref_cnt_q <= '0;
         else ref_cnt_q <= ref_cnt_q + RC_W'(1);
         tick_q <= (ref_cnt_q == RC_W'(REFRESH_DIV - 1));
         if (tick_q) begin
            anode_q   <= ~(8'd1 << idx_q);
            segment_q <= (cur_blank && sdm.blank_lz) ? 7'h7F : seg_decode(cur_nib);
            idx_q     <= (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
         end
      end
   end

   assign sdm.busy     = busy_q;
   assign sdm.overflow = overflow_q;
   assign sdm.anode    = anode_q;
   assign sdm.segment  = segment_q;
endmodule

// File: tb/tb_score_display_mux.sv
// Randomized bench for score_display_mux, checked against a decimal-arithmetic display model.
module tb_score_display_mux;
   localparam int ND  = 4;
   localparam int SW  = 14;
   localparam int DIV = 4;
   localparam int MAXV = 9999;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   logic exp_ovf;

   logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   score_display_mux_if #(.SCORE_W(SW)) sdm ();

   score_display_mux #(
      .NUM_DIGITS (ND),
      .SCORE_W    (SW),
      .REFRESH_DIV(DIV)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .sdm  (sdm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Strobe s0, optionally strobe s1/s2 at busy cycle t1/t2, and count busy cycles.
   task automatic run_load(input int s0, input int s1, input int t1, input int s2, input int t2,
                           output int nb);
      int guard;
      @(negedge clk);
      sdm.score       = SW'(s0);
      sdm.score_valid = 1'b1;
      @(negedge clk);
      sdm.score_valid = 1'b0;
      chk("ovf_hold_during_busy", 32'(sdm.overflow), 32'(exp_ovf));
      nb    = 0;
      guard = 0;
      while (sdm.busy === 1'b1 && guard < 200) begin
         nb++;
         if (t1 != 0 && nb == t1) begin
            sdm.score = SW'(s1);
            sdm.score_valid = 1'b1;
         end else if (t2 != 0 && nb == t2) begin
            sdm.score = SW'(s2);
            sdm.score_valid = 1'b1;
         end else begin
            sdm.score_valid = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      sdm.score_valid = 1'b0;
      if (guard >= 200) chk("busy_timeout", 32'd1, 32'd0);
   endtask

   task automatic scan(output logic [7*ND-1:0] segs, output logic ok);
      logic [ND-1:0] seen;
      logic          bad;
      seen = '0;
      bad  = 1'b0;
      segs = '1;
      for (int c = 0; c < ND * DIV + 4; c++) begin
         @(negedge clk);
         for (int i = 0; i < ND; i++) begin
            if (sdm.anode == 8'(~(8'd1 << i))) begin
               segs[7*i +: 7] = sdm.segment;
               seen[i] = 1'b1;
            end
         end
         if (sdm.anode[7:4] != 4'hF) bad = 1'b1;
      end
      ok = (seen == '1) && !bad;
   endtask

   task automatic expect_display(input int v_in, input logic blank, input string tag);
      logic [7*ND-1:0] segs;
      logic            ok;
      int              v;
      int              p;
      logic [6:0]      e;
      repeat ((ND + 1) * DIV) @(negedge clk);
      scan(segs, ok);
      chk({tag, "_scan"}, 32'(ok), 32'd1);
      v = (v_in > MAXV) ? MAXV : v_in;
      p = 1;
      for (int i = 0; i < ND; i++) begin
         e = (blank && i > 0 && v < p) ? 7'h7F : seg_tbl[(v / p) % 10];
         chk($sformatf("%s_d%0d", tag, i), 32'(segs[7*i +: 7]), 32'(e));
         p = p * 10;
      end
   endtask

   task automatic load_and_check(input int s, input logic blank, input string tag);
      int nb;
      sdm.blank_lz = blank;
      run_load(s, 0, 0, 0, 0, nb);
      chk({tag, "_busy_len"}, 32'(nb), 32'(SW + 1));
      exp_ovf = (s > MAXV);
      chk({tag, "_ovf"}, 32'(sdm.overflow), 32'(exp_ovf));
      expect_display(s, blank, tag);
   endtask

   initial begin
      int          nb;
      int          s;
      logic        b;
      logic        busy_seen;
      logic [7:0]  ea;
      n_checks        = 0;
      n_fail          = 0;
      exp_ovf         = 1'b0;
      sdm.score       = '0;
      sdm.score_valid = 1'b0;
      sdm.blank_lz    = 1'b0;
      rst_n           = 1'b1;
      #1 rst_n = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_anode", 32'(sdm.anode), 32'h0FF);
      chk("rst_segment", 32'(sdm.segment), 32'h07F);
      chk("rst_busy", 32'(sdm.busy), 32'd0);
      chk("rst_ovf", 32'(sdm.overflow), 32'd0);

      // Release between edges so that the next posedge is cycle 1.
      #1 rst_n = 1'b1;
      for (int k = 1; k <= 6 * DIV; k++) begin
         @(negedge clk);
         ea = (k < DIV + 1) ? 8'hFF : 8'(~(8'd1 << (((k - DIV - 1) / DIV) % ND)));
         chk($sformatf("dark_anode_c%0d", k), 32'(sdm.anode), 32'(ea));
         chk($sformatf("dark_seg_c%0d", k), 32'(sdm.segment), (k < DIV + 1) ? 32'h7F : 32'h40);
      end

      load_and_check(1234, 1'b0, "conv1234");
      load_and_check(12000, 1'b0, "sat12000");
      load_and_check(5, 1'b0, "load5");

      load_and_check(7, 1'b1, "blank7");
      sdm.blank_lz = 1'b0;
      expect_display(7, 1'b0, "noblank7");
      load_and_check(0, 1'b1, "blank0");

      sdm.blank_lz = 1'b0;
      run_load(42, 99, 3, 123, 8, nb);
      chk("b2b_busy_len", 32'(nb), 32'(2 * (SW + 1)));
      exp_ovf = 1'b0;
      chk("b2b_ovf", 32'(sdm.overflow), 32'd0);
      expect_display(123, 1'b0, "b2b");

      for (int r = 0; r < 6; r++) begin
         s = $urandom_range(0, (1 << SW) - 1);
         b = 1'($urandom_range(0, 1));
         if (r == 0) s = 10000;
         if (r == 1) s = 9999;
         load_and_check(s, b, $sformatf("rnd%0d", r));
      end

      load_and_check(12000, 1'b0, "presat");

      sdm.blank_lz = 1'b0;
      @(negedge clk);
      sdm.score       = SW'(9999);
      sdm.score_valid = 1'b1;
      @(negedge clk);
      sdm.score_valid = 1'b0;
      for (int k = 1; k < 6; k++) begin
         sdm.score       = SW'(555);
         sdm.score_valid = (k == 3);
         @(negedge clk);
      end
      sdm.score_valid = 1'b0;
      chk("busy_before_rst", 32'(sdm.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_anode", 32'(sdm.anode), 32'h0FF);
      chk("midrst_segment", 32'(sdm.segment), 32'h07F);
      chk("midrst_busy", 32'(sdm.busy), 32'd0);
      chk("midrst_ovf", 32'(sdm.overflow), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      busy_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (sdm.busy !== 1'b0) busy_seen = 1'b1;
      end
      chk("no_pending_after_rst", 32'(busy_seen), 32'd0);
      expect_display(0, 1'b0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
